axi_read_arbiter: RTL and testbench

- Two-master, one-slave AXI4 read-channel arbiter for the core's single memory port.
- Requesters: IFU (instruction fetch) and LSU (load path of the memory stage).
- Grants one master at a time, holds the grant through the last R beat, then re-arbitrates.
- Write channels connect LSU to slave directly and do not pass through this block.

---
 rtl/axi_read_arbiter.sv | 95 +++++++++
 tb/tb_axi_read_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin arbiter between IFU and LSU for one AXI4 read slave
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ifu_ar*/ifu_r*                 IFU read address / read data channels
//   lsu_ar*/lsu_r*                 LSU read address / read data channels
//   s_ar*/s_r*                     shared slave read address / read data channels
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic [2:0]        ifu_arsize,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [7:0]        lsu_arlen,
    input  logic [2:0]        lsu_arsize,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rvalid,
    output logic              s_rready
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;
    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic       last_lsu_q, last_lsu_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ar_phase, r_phase, sel_ifu, sel_lsu;
    // Output steering decodes the registered state/owner; reset forces everything quiet.
    always_comb begin
        sel_ifu     = owner_q == OWN_IFU;
        sel_lsu     = owner_q == OWN_LSU;
        ar_phase    = !reset && state_q == AR;
        r_phase     = !reset && state_q == R;
        s_araddr    = ar_phase ? (sel_lsu ? lsu_araddr : ifu_araddr) : '0;
        s_arlen     = ar_phase ? (sel_lsu ? lsu_arlen : ifu_arlen) : '0;
        s_arsize    = ar_phase ? (sel_lsu ? lsu_arsize : ifu_arsize) : '0;
        s_arvalid   = ar_phase;
        ifu_arready = ar_phase && sel_ifu && s_arready;
        lsu_arready = ar_phase && sel_lsu && s_arready;
        s_rready    = r_phase && (sel_lsu ? lsu_rready : ifu_rready);
        ifu_rvalid  = r_phase && sel_ifu && s_rvalid;
        lsu_rvalid  = r_phase && sel_lsu && s_rvalid;
        ifu_rdata   = (r_phase && sel_ifu) ? s_rdata : '0;
        lsu_rdata   = (r_phase && sel_lsu) ? s_rdata : '0;
    end
    // On a tie the master that did not win last time gets the grant.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_lsu_d = last_lsu_q;
        cnt_d      = cnt_q;
        if (state_q == IDLE && (ifu_arvalid || lsu_arvalid)) begin
            owner_d    = (lsu_arvalid && (!ifu_arvalid || !last_lsu_q)) ? OWN_LSU : OWN_IFU;
            last_lsu_d = owner_d == OWN_LSU;
            state_d    = AR;
        end else if (state_q == AR && s_arready) begin
            cnt_d   = sel_lsu ? lsu_arlen : ifu_arlen;
            state_d = R;
        end else if (state_q == R && s_rvalid && s_rready) begin
            cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
            owner_d = (cnt_q == 8'd0) ? OWN_NONE : owner_q;
            state_d = (cnt_q == 8'd0) ? IDLE : R;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            last_lsu_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_lsu_q <= last_lsu_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed scoreboard bench for axi_read_arbiter
// Ports: none (drives clk/reset and both masters, models the slave in-line)
module tb_axi_read_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] IFU_A = 32'h8000_0000;
    localparam logic [31:0] LSU_A = 32'h4000_1000;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] ifu_araddr = IFU_A, lsu_araddr = LSU_A, s_araddr;
    logic [7:0]        ifu_arlen = '0, lsu_arlen = '0, s_arlen;
    logic [2:0]        ifu_arsize = 3'd2, lsu_arsize = 3'd1, s_arsize;
    logic              ifu_arvalid = 1'b0, lsu_arvalid = 1'b0, s_arvalid;
    logic              ifu_arready, lsu_arready, s_arready = 1'b0;
    logic [DATA_W-1:0] ifu_rdata, lsu_rdata, s_rdata = '0;
    logic              ifu_rvalid, lsu_rvalid, s_rvalid = 1'b0;
    logic              ifu_rready = 1'b1, lsu_rready = 1'b1, s_rready;
    logic [31:0]       exp_q[$];
    int                total = 0, bad = 0, w;

    always #5 clk = ~clk;

    axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        s_rvalid = 1'b1;
        #1;
        chk("rst_vr", {s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}, 0);
        chk("rst_ar", {s_araddr, s_arlen, s_arsize}, 0);
        chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
        s_rvalid = 1'b0;
        exp_q.delete();
    endtask

    // Acts as the slave for one transaction granted to `who` (0=IFU, 1=LSU).
    task automatic serve(input bit who, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] base, input int stall, input bit rearm,
                         input int lsu_at, output int waited);
        int idx, n, st;
        logic rr;
        logic [31:0] e;
        waited = 0;
        st = stall;
        #1;
        while (!s_arvalid && waited < 20) begin
            @(negedge clk);
            waited++;
            #1;
        end
        chk("ar_seen", s_arvalid, 1);
        chk("araddr", s_araddr, addr);
        chk("arlen", s_arlen, len);
        chk("arsize", s_arsize, who ? 3'd1 : 3'd2);
        s_arready = 1'b1;
        #1;
        chk("arready_own", who ? lsu_arready : ifu_arready, 1);
        chk("arready_oth", who ? ifu_arready : lsu_arready, 0);
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(base + i);
        @(negedge clk);
        s_arready = 1'b0;
        if (!rearm) begin
            if (who) lsu_arvalid = 1'b0;
            else ifu_arvalid = 1'b0;
        end
        idx = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            if (idx == lsu_at) lsu_arvalid = 1'b1;
            s_rvalid = 1'b1;
            s_rdata = base + idx;
            rr = (st > 0) ? 1'b0 : 1'b1;
            if (st > 0) st--;
            if (who) lsu_rready = rr;
            else ifu_rready = rr;
            #1;
            chk("s_rready", s_rready, rr);
            chk("s_arvalid_r", s_arvalid, 0);
            chk("oth_rvalid", who ? ifu_rvalid : lsu_rvalid, 0);
            chk("oth_arready", who ? ifu_arready : lsu_arready, 0);
            chk("own_rvalid", who ? lsu_rvalid : ifu_rvalid, 1);
            if (rr) begin
                e = exp_q.pop_front();
                chk("rdata", who ? lsu_rdata : ifu_rdata, e);
                idx++;
            end
            @(negedge clk);
            n++;
        end
        chk("beats_left", exp_q.size(), 0);
        exp_q.delete();
        // Slave keeps rvalid high in the IDLE cycle that follows the last beat.
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        #1;
        chk("post_idle", {s_arvalid, s_rready, ifu_rvalid, lsu_rvalid}, 0);
        s_rvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // single-beat IFU fetch, one-cycle arbitration bubble
        ifu_arlen = 8'd0;
        ifu_arvalid = 1'b1;
        serve(0, IFU_A, 8'd0, 32'h0000_0413, 0, 0, -1, w);
        chk("bubble1", w, 1);
        // simultaneous first request after reset goes to LSU, then IFU after one IDLE cycle
        do_reset();
        ifu_arlen = 8'd1;
        lsu_arlen = 8'd1;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        serve(1, LSU_A, 8'd1, 32'h100, 0, 0, -1, w);
        chk("bubble_lsu", w, 1);
        serve(0, IFU_A, 8'd1, 32'h200, 0, 0, -1, w);
        chk("gap_ifu", w, 1);
        // continuous contention: LSU, IFU, LSU, IFU
        ifu_arlen = 8'd0;
        lsu_arlen = 8'd2;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        serve(1, LSU_A, 8'd2, 32'h310, 0, 1, -1, w);
        serve(0, IFU_A, 8'd0, 32'h320, 0, 1, -1, w);
        serve(1, LSU_A, 8'd2, 32'h330, 0, 1, -1, w);
        serve(0, IFU_A, 8'd0, 32'h340, 0, 0, -1, w);
        lsu_arvalid = 1'b0;
        // IFU 4-beat burst, LSU request arrives during beat 2 and waits
        ifu_arlen = 8'd3;
        lsu_arlen = 8'd0;
        ifu_arvalid = 1'b1;
        serve(0, IFU_A, 8'd3, 32'd1, 0, 0, 1, w);
        serve(1, LSU_A, 8'd0, 32'h400, 0, 0, -1, w);
        chk("lsu_after_ifu", w, 1);
        // LSU back-pressure for 3 cycles holds the burst
        lsu_arlen = 8'd2;
        lsu_arvalid = 1'b1;
        serve(1, LSU_A, 8'd2, 32'h500, 3, 0, -1, w);
        // longest burst
        ifu_arlen = 8'd255;
        ifu_arvalid = 1'b1;
        serve(0, IFU_A, 8'd255, 32'h1000, 0, 0, -1, w);
        // reset in the middle of an 8-beat burst
        ifu_arlen = 8'd7;
        ifu_arvalid = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_ar", s_arvalid, 1);
        s_arready = 1'b1;
        @(negedge clk);
        s_arready = 1'b0;
        ifu_arvalid = 1'b0;
        s_rvalid = 1'b1;
        s_rdata = 32'hdead_0000;
        ifu_rready = 1'b1;
        #1;
        chk("mid_in_r", ifu_rvalid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_vr", {s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}, 0);
        chk("mid_rst_rdata", {ifu_rdata, lsu_rdata}, 0);
        s_rvalid = 1'b0;
        ifu_arlen = 8'd1;
        ifu_arvalid = 1'b1;
        serve(0, IFU_A, 8'd1, 32'h600, 0, 0, -1, w);
        chk("fresh_after_rst", w, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
